switch_input_ctrl: RTL and testbench
====================================

Name: switch_input_ctrl

Overview:
- Parametrised, Avalon-MM-mapped switch/button front end for the clock design.
- Each of NUM_CH asynchronous inputs is synchronised, debounced and edge-detected.
- Rising and falling edges are captured into sticky, per-channel-enabled bits that drive one level interrupt to the Nios II.
- The clean switch levels also go straight to downstream clock-control logic.

Parameters:
- NUM_CH, 10, number of input channels; legal range 1..32.
- DEBOUNCE_CYCLES, 500000, cycles an input must hold a new level before it is accepted; legal minimum 2. Default is 10 ms at 50 MHz.
- DATA_WIDTH, 32, Avalon data width; fixed at 32.
- ADDR_WIDTH, 3, Avalon word address width.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset
- avs_address  in  ADDR_WIDTH  word address
- avs_read  in  1  read strobe
- avs_write  in  1  write strobe
- avs_writedata  in  32  write data
- avs_readdata  out  32  registered read data
- avs_waitrequest  out  1  constant 0
- sw_in  in  NUM_CH  raw asynchronous switch inputs
- sw_state  out  NUM_CH  debounced (effective) levels
- irq  out  1  level interrupt, active high

Behaviour:
- Clock and reset: one clock, clk. Reset reset_n is asynchronous and active-low.
- Reset values: all flops 0, including sw_state, irq, avs_readdata, all registers and all counters.
- Synchroniser: two flops per channel.
- Debounce, per channel, with a counter of width $clog2(DEBOUNCE_CYCLES):
  - sync == stable: counter cleared.
  - sync != stable: counter increments.
  - On the cycle the counter equals DEBOUNCE_CYCLES-1: stable takes sync and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES is discarded.
- Latency: sw_in change to sw_state change = 2 + DEBOUNCE_CYCLES cycles.
- Input held high through reset: it debounces to 1 after reset and produces a rising edge like any other transition.
- Edge detect: compares sw_state with its one-cycle-delayed copy.
  - rise = now 1, was 0. fall = now 0, was 1.
  - EDGE_CAP[i] is set if (rise & RISE_EN[i]) | (fall & FALL_EN[i]).
- Register map (word addresses):
  - 0 STATE (RO): sw_state.
  - 1 IRQ_MASK (RW).
  - 2 EDGE_CAP (W1C): writing 1 clears the bit; writing 0 has no effect.
  - 3 RISE_EN (RW).
  - 4 FALL_EN (RW).
  - 5 CTRL (RW): bit0 = IRQ global enable; other bits read 0.
  - 6, 7: reserved.
  - Bits above NUM_CH read 0 and ignore writes.
- Simultaneous W1C clear and new edge on the same bit in the same cycle: set wins (bit stays 1).
- irq: registered; irq = CTRL[0] & |(EDGE_CAP & IRQ_MASK). It asserts 1 cycle after EDGE_CAP/mask/enable make it true and deasserts 1 cycle after the clear.
- Avalon interface:
  - waitrequest is always 0.
  - Read data is valid the cycle after avs_read (1-cycle read latency, fixed).
  - avs_readdata holds its value when no read is active.
  - Unmapped or reserved addresses read 0; writes to them are ignored.
  - Read and write in the same cycle: both are performed; the read returns the pre-write value.
- Reset mid-debounce: counters and stable levels are cleared immediately (asynchronous); no edge is captured as a result of the reset.

Optional Feature:
- Macro: SWITCH_FORCE_EN.
- With the macro defined:
  - Address 6 is FORCE_MASK (RW) and address 7 is FORCE_VAL (RW), both reset to 0.
  - Effective level per channel = FORCE_MASK[i] ? FORCE_VAL[i] : debounced[i].
  - sw_state, STATE and edge detection all use the effective level, so forcing generates edges.
  - A write takes effect on sw_state in the following cycle.
- Without the macro: addresses 6 and 7 are reserved (read 0, writes ignored), and effective level = debounced.

Decomposition:
- Package switch_input_pkg:
  - register address localparams: ADDR_STATE, ADDR_IRQ_MASK, ADDR_EDGE_CAP, ADDR_RISE_EN, ADDR_FALL_EN, ADDR_CTRL, ADDR_FORCE_MASK, ADDR_FORCE_VAL;
  - MAX_CH = 32;
  - CTRL bit index constants.
- Sub-module sw_debounce: one channel, containing the 2-flop synchroniser, the debounce counter and the stable flop. Parameter DEBOUNCE_CYCLES. Instantiated NUM_CH times through a generate loop.
- The top level holds the registers, edge logic, irq and the Avalon decode.

Test Plan (bench uses NUM_CH=10, DEBOUNCE_CYCLES=4):
- Reset then idle: all readback 0, irq 0. Hold sw_in=10'h001 → sw_state[0]=1 exactly 6 cycles after sw_in rises.
- Glitch: sw_in[3] high for 3 cycles, then low → sw_state[3] stays 0; EDGE_CAP reads 0.
- Interrupt path:
  - Setup: RISE_EN=10'h004, IRQ_MASK=10'h004, CTRL=1.
  - Stimulus: raise sw_in[2].
  - Expected: EDGE_CAP=10'h004; irq=1 one cycle after the capture. Writing EDGE_CAP=0 leaves irq=1; writing EDGE_CAP=10'h004 drops irq the following cycle.
- Collision: a fall on ch5 (FALL_EN[5]=1) in the same cycle as a W1C write of 10'h020 → EDGE_CAP[5] stays 1.
- Address checks:
  - Read address 6 with the macro undefined → 0, returned the cycle after avs_read.
  - Write 32'hFFFFFFFF to IRQ_MASK → reads back 32'h000003FF.
- SWITCH_FORCE_EN defined:
  - FORCE_MASK=10'h001, FORCE_VAL=10'h001 with sw_in=0 → sw_state[0]=1 next cycle; rising edge captured if RISE_EN[0]=1.
  - FORCE_MASK=0 → sw_state[0] returns to 0.
  - Assert reset_n low mid-force → FORCE_MASK=0, sw_state=0.

Source files
------------

// File: rtl/switch_input_pkg.sv
// Shared register addresses and constants for the switch input controller.
// The optional SWITCH_FORCE_EN build maps FORCE_MASK/FORCE_VAL at addresses 6 and 7.
package switch_input_pkg;
   localparam int MAX_CH          = 32;

   localparam int ADDR_STATE      = 0;
   localparam int ADDR_IRQ_MASK   = 1;
   localparam int ADDR_EDGE_CAP   = 2;
   localparam int ADDR_RISE_EN    = 3;
   localparam int ADDR_FALL_EN    = 4;
   localparam int ADDR_CTRL       = 5;
   localparam int ADDR_FORCE_MASK = 6;
   localparam int ADDR_FORCE_VAL  = 7;

   localparam int CTRL_IRQ_EN_BIT = 0;
endpackage

// File: rtl/sw_debounce.sv
// One switch channel: two-flop synchroniser followed by a hold-time debouncer.
module sw_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic sw_raw,
   output logic sw_stable
);
   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic             sync_1;
   logic             sync_2;
   logic [CNT_W-1:0] count;

   // A new level is accepted only after it has been seen for DEBOUNCE_CYCLES cycles in a row.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_1    <= 1'b0;
         sync_2    <= 1'b0;
         count     <= '0;
         sw_stable <= 1'b0;
      end else begin
         sync_1 <= sw_raw;
         sync_2 <= sync_1;
         if (sync_2 == sw_stable) begin
            count <= '0;
         end else if (count == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            sw_stable <= sync_2;
            count     <= '0;
         end else begin
            count <= count + 1'b1;
         end
      end
   end
endmodule

// File: rtl/switch_input_ctrl.sv
// Avalon-MM switch front end: debounced levels, sticky edge capture and a level irq.
// Define SWITCH_FORCE_EN to add FORCE_MASK/FORCE_VAL override registers.
module switch_input_ctrl
   import switch_input_pkg::*;
#(
   parameter int NUM_CH          = 10,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int DATA_WIDTH      = 32,
   parameter int ADDR_WIDTH      = 3
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [ADDR_WIDTH-1:0] avs_address,
   input  logic                  avs_read,
   input  logic                  avs_write,
   input  logic [31:0]           avs_writedata,
   output logic [31:0]           avs_readdata,
   output logic                  avs_waitrequest,
   input  logic [NUM_CH-1:0]     sw_in,
   output logic [NUM_CH-1:0]     sw_state,
   output logic                  irq
);
   logic [NUM_CH-1:0] debounced;
   logic [NUM_CH-1:0] prev_state;
   logic [NUM_CH-1:0] irq_mask;
   logic [NUM_CH-1:0] edge_cap;
   logic [NUM_CH-1:0] rise_en;
   logic [NUM_CH-1:0] fall_en;
   logic              ctrl_irq_en;
   logic [NUM_CH-1:0] wdata_ch;
   logic [NUM_CH-1:0] new_edges;
   logic [31:0]       rd_value;
   logic              unused_wdata;

   assign avs_waitrequest = 1'b0;
   assign wdata_ch        = avs_writedata[NUM_CH-1:0];
   assign unused_wdata    = ^{avs_writedata, DATA_WIDTH[0], MAX_CH[0]};

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
         .clk       (clk),
         .reset_n   (reset_n),
         .sw_raw    (sw_in[i]),
         .sw_stable (debounced[i])
      );
   end

`ifdef SWITCH_FORCE_EN
   logic [NUM_CH-1:0] force_mask;
   logic [NUM_CH-1:0] force_val;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         force_mask <= '0;
         force_val  <= '0;
      end else if (avs_write) begin
         if (avs_address == ADDR_WIDTH'(ADDR_FORCE_MASK)) force_mask <= wdata_ch;
         if (avs_address == ADDR_WIDTH'(ADDR_FORCE_VAL))  force_val  <= wdata_ch;
      end
   end

   assign sw_state = (force_mask & force_val) | (~force_mask & debounced);
`else
   assign sw_state = debounced;
`endif

   assign new_edges = (sw_state & ~prev_state & rise_en) | (~sw_state & prev_state & fall_en);

   // Edge capture is sticky; a new edge beats a same-cycle W1C clear of that bit.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev_state  <= '0;
         irq_mask    <= '0;
         edge_cap    <= '0;
         rise_en     <= '0;
         fall_en     <= '0;
         ctrl_irq_en <= 1'b0;
         irq         <= 1'b0;
      end else begin
         prev_state <= sw_state;
         irq        <= ctrl_irq_en & |(edge_cap & irq_mask);
         if (avs_write && avs_address == ADDR_WIDTH'(ADDR_EDGE_CAP))
            edge_cap <= (edge_cap & ~wdata_ch) | new_edges;
         else
            edge_cap <= edge_cap | new_edges;
         if (avs_write) begin
            if (avs_address == ADDR_WIDTH'(ADDR_IRQ_MASK)) irq_mask    <= wdata_ch;
            if (avs_address == ADDR_WIDTH'(ADDR_RISE_EN))  rise_en     <= wdata_ch;
            if (avs_address == ADDR_WIDTH'(ADDR_FALL_EN))  fall_en     <= wdata_ch;
            if (avs_address == ADDR_WIDTH'(ADDR_CTRL))     ctrl_irq_en <= avs_writedata[CTRL_IRQ_EN_BIT];
         end
      end
   end

   always_comb begin
      rd_value = '0;
      case (avs_address)
         ADDR_WIDTH'(ADDR_STATE):      rd_value[NUM_CH-1:0] = sw_state;
         ADDR_WIDTH'(ADDR_IRQ_MASK):   rd_value[NUM_CH-1:0] = irq_mask;
         ADDR_WIDTH'(ADDR_EDGE_CAP):   rd_value[NUM_CH-1:0] = edge_cap;
         ADDR_WIDTH'(ADDR_RISE_EN):    rd_value[NUM_CH-1:0] = rise_en;
         ADDR_WIDTH'(ADDR_FALL_EN):    rd_value[NUM_CH-1:0] = fall_en;
         ADDR_WIDTH'(ADDR_CTRL):       rd_value[CTRL_IRQ_EN_BIT] = ctrl_irq_en;
`ifdef SWITCH_FORCE_EN
         ADDR_WIDTH'(ADDR_FORCE_MASK): rd_value[NUM_CH-1:0] = force_mask;
         ADDR_WIDTH'(ADDR_FORCE_VAL):  rd_value[NUM_CH-1:0] = force_val;
`endif
         default:                      rd_value = '0;
      endcase
   end

   // Read data is registered and held between reads; it reflects pre-write register contents.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         avs_readdata <= '0;
      else if (avs_read)
         avs_readdata <= rd_value;
   end
endmodule

// File: tb/tb_switch_input_ctrl.sv
// Directed, table-driven bench for switch_input_ctrl (NUM_CH=10, DEBOUNCE_CYCLES=4).
// Force-override checks run only when SWITCH_FORCE_EN is defined.
module tb_switch_input_ctrl;
   localparam int NUM_CH = 10;
   localparam int DEB    = 4;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic [2:0]        avs_address = '0;
   logic              avs_read = 1'b0;
   logic              avs_write = 1'b0;
   logic [31:0]       avs_writedata = '0;
   logic [31:0]       avs_readdata;
   logic              avs_waitrequest;
   logic [NUM_CH-1:0] sw_in = '0;
   logic [NUM_CH-1:0] sw_state;
   logic              irq;

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      logic        wr;
      logic [2:0]  addr;
      logic [31:0] data;
      logic [31:0] exp;
   } vec_t;

   vec_t        tbl[24];
   logic [31:0] rd;

   switch_input_ctrl #(.NUM_CH(NUM_CH), .DEBOUNCE_CYCLES(DEB), .DATA_WIDTH(32), .ADDR_WIDTH(3)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .avs_address     (avs_address),
      .avs_read        (avs_read),
      .avs_write       (avs_write),
      .avs_writedata   (avs_writedata),
      .avs_readdata    (avs_readdata),
      .avs_waitrequest (avs_waitrequest),
      .sw_in           (sw_in),
      .sw_state        (sw_state),
      .irq             (irq)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic avWrite(input logic [2:0] addr, input logic [31:0] data);
      @(negedge clk);
      avs_address   = addr;
      avs_writedata = data;
      avs_write     = 1'b1;
      @(posedge clk);
      #1 avs_write = 1'b0;
   endtask

   task automatic avRead(input logic [2:0] addr, output logic [31:0] data);
      @(negedge clk);
      avs_address = addr;
      avs_read    = 1'b1;
      @(posedge clk);
      #1 avs_read = 1'b0;
      data = avs_readdata;
   endtask

   task automatic applyStimulus(input vec_t v, input int idx);
      if (v.wr) begin
         avWrite(v.addr, v.data);
      end else begin
         avRead(v.addr, rd);
         checkOutput($sformatf("table[%0d] rd addr %0d", idx, v.addr), rd, v.exp);
      end
   endtask

   // Polls sw_state[ch] after each rising edge until it equals val or the budget runs out.
   task automatic waitState(input int ch, input logic val, input int budget);
      bit seen = 1'b0;
      for (int c = 0; c < budget; c++) begin
         @(posedge clk);
         #1;
         if (sw_state[ch] === val) begin
            seen = 1'b1;
            break;
         end
      end
      checkOutput($sformatf("wait sw_state[%0d]", ch), {31'b0, seen}, 32'd1);
   endtask

   initial begin
      for (int i = 0; i < 8; i++) tbl[i] = '{1'b0, 3'(i), 32'h0, 32'h0};
      tbl[8]  = '{1'b1, 3'd1, 32'hFFFF_FFFF, 32'h0};
      tbl[9]  = '{1'b0, 3'd1, 32'h0, 32'h0000_03FF};
      tbl[10] = '{1'b1, 3'd3, 32'hFFFF_FFFF, 32'h0};
      tbl[11] = '{1'b0, 3'd3, 32'h0, 32'h0000_03FF};
      tbl[12] = '{1'b1, 3'd4, 32'h0000_0155, 32'h0};
      tbl[13] = '{1'b0, 3'd4, 32'h0, 32'h0000_0155};
      tbl[14] = '{1'b1, 3'd5, 32'hFFFF_FFFF, 32'h0};
      tbl[15] = '{1'b0, 3'd5, 32'h0, 32'h0000_0001};
      tbl[16] = '{1'b1, 3'd2, 32'hFFFF_FFFF, 32'h0};
      tbl[17] = '{1'b0, 3'd2, 32'h0, 32'h0};
      tbl[18] = '{1'b1, 3'd1, 32'h0, 32'h0};
      tbl[19] = '{1'b1, 3'd3, 32'h0, 32'h0};
      tbl[20] = '{1'b1, 3'd4, 32'h0, 32'h0};
      tbl[21] = '{1'b1, 3'd5, 32'h0, 32'h0};
      tbl[22] = '{1'b0, 3'd5, 32'h0, 32'h0};
      tbl[23] = '{1'b0, 3'd1, 32'h0, 32'h0};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset sw_state", 32'(sw_state), 32'h0);
      checkOutput("reset irq", {31'b0, irq}, 32'h0);
      checkOutput("reset readdata", avs_readdata, 32'h0);
      checkOutput("waitrequest", {31'b0, avs_waitrequest}, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;

      for (int i = 0; i < 24; i++) applyStimulus(tbl[i], i);

      // Read and write in the same cycle returns the old value
      @(negedge clk);
      avs_address = 3'd1; avs_writedata = 32'h3; avs_write = 1'b1; avs_read = 1'b1;
      @(posedge clk);
      #1 avs_write = 1'b0; avs_read = 1'b0;
      checkOutput("rd+wr old value", avs_readdata, 32'h0);
      repeat (3) @(posedge clk);
      #1 checkOutput("readdata held", avs_readdata, 32'h0);
      avRead(3'd1, rd);
      checkOutput("rd+wr new value", rd, 32'h3);

      // Debounce latency on channel 0
      @(negedge clk);
      sw_in[0] = 1'b1;
      repeat (5) @(posedge clk);
      #1 checkOutput("latency 5 cycles", 32'(sw_state[0]), 32'h0);
      @(posedge clk);
      #1 checkOutput("latency 6 cycles", 32'(sw_state[0]), 32'h1);

      // Three-cycle glitch on channel 3 is dropped
      @(negedge clk);
      sw_in[3] = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      sw_in[3] = 1'b0;
      repeat (10) @(posedge clk);
      #1 checkOutput("glitch sw_state[3]", 32'(sw_state[3]), 32'h0);
      avRead(3'd2, rd);
      checkOutput("glitch EDGE_CAP", rd, 32'h0);

      // Interrupt path on channel 2
      avWrite(3'd3, 32'h004);
      avWrite(3'd1, 32'h004);
      avWrite(3'd5, 32'h001);
      @(negedge clk);
      sw_in[2] = 1'b1;
      waitState(2, 1'b1, 20);
      @(posedge clk);
      #1 checkOutput("irq before capture seen", {31'b0, irq}, 32'h0);
      @(posedge clk);
      #1 checkOutput("irq asserted", {31'b0, irq}, 32'h1);
      avRead(3'd2, rd);
      checkOutput("EDGE_CAP rise ch2", rd, 32'h004);
      avWrite(3'd2, 32'h0);
      repeat (2) @(posedge clk);
      #1 checkOutput("irq after W1C 0", {31'b0, irq}, 32'h1);
      avWrite(3'd2, 32'h004);
      checkOutput("irq same cycle as clear", {31'b0, irq}, 32'h1);
      @(posedge clk);
      #1 checkOutput("irq dropped", {31'b0, irq}, 32'h0);

      // Fall on channel 5 collides with a W1C of that bit
      @(negedge clk);
      sw_in[5] = 1'b1;
      waitState(5, 1'b1, 20);
      avWrite(3'd4, 32'h020);
      @(negedge clk);
      sw_in[5] = 1'b0;
      waitState(5, 1'b0, 20);
      avs_address = 3'd2; avs_writedata = 32'h020; avs_write = 1'b1;
      @(posedge clk);
      #1 avs_write = 1'b0;
      avRead(3'd2, rd);
      checkOutput("collision set wins", rd, 32'h020);
      avWrite(3'd2, 32'h020);
      avRead(3'd2, rd);
      checkOutput("collision cleared later", rd, 32'h0);
      avRead(3'd0, rd);
      checkOutput("STATE ch0+ch2", rd, 32'h005);
      checkOutput("irq masked ch5", {31'b0, irq}, 32'h0);

`ifdef SWITCH_FORCE_EN
      @(negedge clk);
      sw_in = '0;
      repeat (10) @(posedge clk);
      avWrite(3'd2, 32'h3FF);
      avWrite(3'd3, 32'h001);
      avWrite(3'd7, 32'h001);
      avWrite(3'd6, 32'h001);
      checkOutput("force sw_state[0]", 32'(sw_state[0]), 32'h1);
      repeat (2) @(posedge clk);
      avRead(3'd2, rd);
      checkOutput("force rise captured", rd, 32'h001);
      avRead(3'd6, rd);
      checkOutput("FORCE_MASK readback", rd, 32'h001);
      avWrite(3'd6, 32'h0);
      checkOutput("unforce sw_state[0]", 32'(sw_state[0]), 32'h0);
      avWrite(3'd6, 32'h001);
      @(negedge clk);
      reset_n = 1'b0;
      #1 checkOutput("reset mid-force sw_state", 32'(sw_state), 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      avRead(3'd6, rd);
      checkOutput("FORCE_MASK after reset", rd, 32'h0);
`endif

      // Asynchronous reset in the middle of a debounce on channel 7
      avWrite(3'd1, 32'h3FF);
      avRead(3'd1, rd);
      checkOutput("IRQ_MASK all", rd, 32'h3FF);
      @(negedge clk);
      sw_in = 10'h080;
      repeat (3) @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      checkOutput("async reset readdata", avs_readdata, 32'h0);
      checkOutput("async reset sw_state", 32'(sw_state), 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (12) @(posedge clk);
      avRead(3'd0, rd);
      checkOutput("STATE after reset", rd, 32'h080);
      avRead(3'd2, rd);
      checkOutput("EDGE_CAP after reset", rd, 32'h0);
      checkOutput("irq after reset", {31'b0, irq}, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
